quad_encoder_bank: RTL

Multi-channel quadrature encoder and push-button front end for the ice40 control-surface designs. It synchronises, debounces and decodes CHANNELS rotary encoders, each with its own push button, into per-channel signed-offset step counters. It also provides an atomic snapshot-and-clear port that the SPI shifter samples at chip-select fall. Compared with the single fixed 8-bit encoder it succeeds, it adds a channel count, a counter width, a debounce filter, illegal-transition detection and overflow flags.

---
 rtl/quad_encoder_bank_if.sv | 26 ++
 rtl/quad_encoder_bank.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/quad_encoder_bank_if.sv
// Encoder pin / snapshot bus for quad_encoder_bank.
// The master drives the raw pins and snap; the slave (the bank) returns the snapshot.
interface quad_encoder_bank_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8
);
  logic [CHANNELS-1:0]       quad_a;
  logic [CHANNELS-1:0]       quad_b;
  logic [CHANNELS-1:0]       btn_n;
  logic                      snap;
  logic [CHANNELS*CNT_W-1:0] snap_cnt;
  logic [CHANNELS-1:0]       snap_btn;
  logic [CHANNELS-1:0]       snap_err;
  logic [CHANNELS-1:0]       snap_ovf;
  logic                      snap_valid;

  modport master (
    output quad_a, quad_b, btn_n, snap,
    input  snap_cnt, snap_btn, snap_err, snap_ovf, snap_valid
  );

  modport slave (
    input  quad_a, quad_b, btn_n, snap,
    output snap_cnt, snap_btn, snap_err, snap_ovf, snap_valid
  );
endinterface

// File: rtl/quad_encoder_bank.sv
// Multi-channel quadrature encoder + push-button front end with atomic snapshot-and-clear.
// Define QENC_SAT_EN to saturate the step counters instead of wrapping them.
module quad_encoder_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DEB_LEN  = 3
) (
  input  logic               clk,
  input  logic               reset,
  quad_encoder_bank_if.slave bus
);
  localparam int unsigned NSIG  = 3 * CHANNELS;
  localparam int unsigned RUN_W = 3;
  localparam logic [CNT_W-1:0] CENTER  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Signal vector layout: A at [c], B at [CHANNELS+c], btn_n at [2*CHANNELS+c]
  logic [NSIG-1:0]                  raw, sync1_q, sync2_q, filt_q, filt_d;
  logic [NSIG-1:0][RUN_W-1:0]       run_q, run_d;
  logic [DIV_W-1:0]                 div_q;
  logic                             tick, primed_q;
  logic [CHANNELS-1:0]              up_d, dn_d, ill_d, up_q, dn_q, ill_q, ovf_evt;
  logic [CHANNELS-1:0]              err_q, ovf_q;
  logic [CHANNELS-1:0][CNT_W-1:0]   cnt_q, cnt_run, cnt_snap;

  assign raw  = {bus.btn_n, bus.quad_b, bus.quad_a};
  assign tick = &div_q;

  // Gray position: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] qpos(input logic a, input logic b);
    return {a, a ^ b};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      div_q    <= '0;
      primed_q <= 1'b0;
      filt_q   <= '1;
      run_q    <= '0;
      up_q     <= '0;
      dn_q     <= '0;
      ill_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      div_q    <= div_q + DIV_W'(1);
      primed_q <= primed_q | tick;
      filt_q   <= filt_d;
      run_q    <= run_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      ill_q    <= ill_d;
    end
  end

  // Debounce; the first tick after reset loads the filters directly (priming)
  always_comb begin
    filt_d = filt_q;
    run_d  = run_q;
    if (tick) begin
      for (int s = 0; s < int'(NSIG); s++) begin
        if (!primed_q) begin
          filt_d[s] = sync2_q[s];
          run_d[s]  = '0;
        end else if (sync2_q[s] == filt_q[s]) begin
          run_d[s] = '0;
        end else if (run_q[s] == RUN_W'(DEB_LEN - 1)) begin
          filt_d[s] = sync2_q[s];
          run_d[s]  = '0;
        end else begin
          run_d[s] = run_q[s] + RUN_W'(1);
        end
      end
    end
  end

  // Step decode from the old and newly accepted filtered positions
  always_comb begin
    logic [1:0] dpos;
    dpos  = '0;
    up_d  = '0;
    dn_d  = '0;
    ill_d = '0;
    if (tick && primed_q) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        dpos = qpos(filt_d[c], filt_d[int'(CHANNELS) + c])
             - qpos(filt_q[c], filt_q[int'(CHANNELS) + c]);
        case (dpos)
          2'd1:    up_d[c]  = 1'b1;
          2'd2:    ill_d[c] = 1'b1;
          2'd3:    dn_d[c]  = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Next count for a normal cycle and for a snap cycle (re-centre, keep the step)
  always_comb begin
    cnt_run  = cnt_q;
    cnt_snap = {CHANNELS{CENTER}};
    ovf_evt  = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      ovf_evt[c] = (up_q[c] && (cnt_q[c] == CNT_MAX)) || (dn_q[c] && (cnt_q[c] == '0));
      if (up_q[c]) begin
        cnt_run[c]  = cnt_q[c] + CNT_W'(1);
        cnt_snap[c] = CENTER + CNT_W'(1);
      end else if (dn_q[c]) begin
        cnt_run[c]  = cnt_q[c] - CNT_W'(1);
        cnt_snap[c] = CENTER - CNT_W'(1);
      end
`ifdef QENC_SAT_EN
      if (ovf_evt[c]) cnt_run[c] = cnt_q[c];
`else
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= {CHANNELS{CENTER}};
      err_q          <= '0;
      ovf_q          <= '0;
      bus.snap_cnt   <= {CHANNELS{CENTER}};
      bus.snap_btn   <= '0;
      bus.snap_err   <= '0;
      bus.snap_ovf   <= '0;
      bus.snap_valid <= 1'b0;
    end else begin
      bus.snap_valid <= bus.snap;
      if (bus.snap) begin
        bus.snap_cnt <= cnt_q;
        bus.snap_btn <= ~filt_q[2*CHANNELS +: CHANNELS];
        bus.snap_err <= err_q;
        bus.snap_ovf <= ovf_q;
        cnt_q        <= cnt_snap;
        err_q        <= ill_q;
        ovf_q        <= ovf_evt;
      end else begin
        cnt_q <= cnt_run;
        err_q <= err_q | ill_q;
        ovf_q <= ovf_q | ovf_evt;
      end
    end
  end
endmodule
